bcd_gray_encoder: RTL and testbench
===================================

BCD_GRAY_ENCODER -- requirements
Module: bcd_gray_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state updates on rising edge); rst input 1 (synchronous active-high reset).
REQ-002 The block SHALL expose these data-input ports: bcd_in input 4 (BCD digit, bit 3 = MSB); bcd_valid input 1 (bcd_in qualified); bcd_ready output 1 (block accepts digit this cycle).
REQ-003 The block SHALL expose these data-output ports: gray_out output 4 (reflected Gray code, bit 3 = MSB); gray_valid output 1 (gray_out qualified); gray_ready input 1 (downstream accepts).
REQ-004 The block SHALL expose these status ports: err_pulse output 1 (one-cycle strobe on a rejected digit); enc_cnt output 8 (count of digits emitted); err_cnt output 8 (count of digits rejected).
REQ-005 The block SHALL have no parameters; all widths are fixed.

Function
REQ-006 A transfer SHALL occur on an edge where bcd_valid && bcd_ready; the output handshake SHALL occur on gray_valid && gray_ready.
REQ-007 The encoding SHALL be: G3=B3, G2=B3^B2, G1=B2^B1, G0=B1^B0.
REQ-008 Digits 0-9 SHALL be valid; digits 10-15 SHALL be invalid.
REQ-009 The output stage SHALL be a single register slot, state EMPTY or FULL; gray_valid SHALL equal FULL.
REQ-010 bcd_ready SHALL be combinational: !gray_valid || gray_ready, with no combinational path from bcd_valid or bcd_in.
REQ-011 Accepting a valid digit SHALL load gray_out and set FULL on the same edge, giving 1-cycle latency to gray_valid.
REQ-012 Accepting an invalid digit SHALL consume it without loading the slot, assert err_pulse for exactly the next cycle, and increment err_cnt.
REQ-013 When FULL && gray_ready && an accepted valid digit coincide, the slot SHALL reload and stay FULL, sustaining one digit per cycle.
REQ-014 When FULL && gray_ready && an accepted invalid digit coincide, the slot SHALL go EMPTY.
REQ-015 When FULL && gray_ready with no accepted input, the slot SHALL go EMPTY.
REQ-016 While FULL && !gray_ready, gray_out SHALL hold stable and bcd_ready SHALL be 0.
REQ-017 enc_cnt SHALL increment on each output handshake and wrap 255 -> 0.
REQ-018 err_cnt SHALL saturate at 255; err_pulse SHALL still assert on rejection when err_cnt = 255.
REQ-019 bcd_in SHALL be ignored whenever bcd_valid = 0.

Reset
REQ-020 On rst = 1 at a clock edge, the block SHALL set gray_valid = 0, gray_out = 4'b0000, err_pulse = 0, enc_cnt = 0, err_cnt = 0, and slot = EMPTY.
REQ-021 bcd_ready SHALL read 1 in the first cycle after reset.
REQ-022 While rst = 1, the block SHALL perform no transfer, and reset SHALL take priority over all simultaneous events.
REQ-023 A reset asserted while FULL SHALL discard the pending digit without counting it.

Structure
REQ-024 A shared package bcd_gray_pkg SHALL hold: typedef bcd_t (logic [3:0]); typedef gray_t (logic [3:0]); constant BCD_MAX = 9; function bin2gray.
REQ-025 The code-conversion logic SHALL be one combinational sub-module, bcd2gray_comb (bcd in, gray out, valid-digit flag out).
REQ-026 The handshake slot, counters and err_pulse logic SHALL live in the top module.

Verification
REQ-027 Scenario 1: the bench SHALL drive bcd_in = 5 valid with gray_ready = 1 -> next cycle gray_valid = 1, gray_out = 0111, then enc_cnt = 1.
REQ-028 Scenario 2: the bench SHALL stream digits 0..9 back-to-back with gray_ready = 1 -> outputs 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101 on consecutive cycles, then enc_cnt = 10.
REQ-029 Scenario 3: the bench SHALL drive bcd_in = 12 valid -> gray_valid stays 0, err_pulse high for 1 cycle, err_cnt = 1.
REQ-030 Scenario 4: the bench SHALL hold gray_ready = 0 after loading 9 -> gray_out = 1101 held, bcd_ready = 0, next digit 3 waits; on release, 1101 then 0010.
REQ-031 Scenario 5: the bench SHALL emit 256 valid digits -> enc_cnt = 0; then feed 300 invalid digits -> err_cnt = 255 with 300 err_pulse strobes.
REQ-032 Scenario 6: the bench SHALL assert rst while FULL with gray_ready = 0 -> next cycle gray_valid = 0, counters = 0, bcd_ready = 1, and the discarded digit never appears.

Source files
------------

// File: rtl/bcd_gray_pkg.sv
// Shared types, limits and the Gray conversion helper for the BCD-to-Gray encoder.
package bcd_gray_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [3:0] gray_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Reflected Gray: each bit is the XOR of itself and the next-higher binary bit.
    function automatic gray_t bin2gray(input bcd_t bin);
        return gray_t'(bin ^ (bin >> 1));
    endfunction

endpackage

// File: rtl/bcd2gray_comb.sv
// Purely combinational BCD-to-Gray conversion with a valid-digit flag (0-9 valid).
module bcd2gray_comb
    import bcd_gray_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [3:0] gray,
    output logic       digit_ok
);

    always_comb begin
        gray     = bin2gray(bcd_t'(bcd));
        digit_ok = (bcd_t'(bcd) <= BCD_MAX);
    end

endmodule

// File: rtl/bcd_gray_encoder.sv
// Ready/valid BCD-to-Gray encoder with a single-entry output slot, error strobe
// and emitted/rejected digit counters.
module bcd_gray_encoder
    import bcd_gray_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_in,
    input  logic       bcd_valid,
    output logic       bcd_ready,
    output logic [3:0] gray_out,
    output logic       gray_valid,
    input  logic       gray_ready,
    output logic       err_pulse,
    output logic [7:0] enc_cnt,
    output logic [7:0] err_cnt
);

    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_t;

    slot_t       slot_q, slot_d;
    gray_t       gray_q, gray_d;
    logic        err_pulse_q, err_pulse_d;
    logic [7:0]  enc_cnt_q, enc_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    gray_t       conv_gray;
    logic        conv_ok;
    logic        accept;
    logic        out_fire;

    bcd2gray_comb u_conv (
        .bcd      (bcd_in),
        .gray     (conv_gray),
        .digit_ok (conv_ok)
    );

    // Ready depends only on slot state and downstream ready, never on the input side.
    assign bcd_ready = (slot_q == SLOT_EMPTY) || gray_ready;
    assign accept    = bcd_valid && bcd_ready;
    assign out_fire  = (slot_q == SLOT_FULL) && gray_ready;

    always_comb begin
        slot_d      = slot_q;
        gray_d      = gray_q;
        err_pulse_d = 1'b0;
        enc_cnt_d   = enc_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (out_fire) begin
            slot_d    = SLOT_EMPTY;
            enc_cnt_d = enc_cnt_q + 8'd1;
        end

        if (accept) begin
            if (conv_ok) begin
                slot_d = SLOT_FULL;
                gray_d = conv_gray;
            end else begin
                err_pulse_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= SLOT_EMPTY;
            gray_q      <= '0;
            err_pulse_q <= 1'b0;
            enc_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            slot_q      <= slot_d;
            gray_q      <= gray_d;
            err_pulse_q <= err_pulse_d;
            enc_cnt_q   <= enc_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign gray_valid = (slot_q == SLOT_FULL);
    assign gray_out   = gray_q;
    assign err_pulse  = err_pulse_q;
    assign enc_cnt    = enc_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_bcd_gray_encoder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level reference model built from a reflected-Gray lookup table.
module tb_bcd_gray_encoder;

    logic       clk;
    logic       rst;
    logic [3:0] bcd_in;
    logic       bcd_valid;
    logic       bcd_ready;
    logic [3:0] gray_out;
    logic       gray_valid;
    logic       gray_ready;
    logic       err_pulse;
    logic [7:0] enc_cnt;
    logic [7:0] err_cnt;

    bcd_gray_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (bcd_ready),
        .gray_out   (gray_out),
        .gray_valid (gray_valid),
        .gray_ready (gray_ready),
        .err_pulse  (err_pulse),
        .enc_cnt    (enc_cnt),
        .err_cnt    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_errors;
    int n_pulses;

    // Reference model state
    int gray_tab[16];
    int m_full, m_gray, m_errp, m_enc, m_err;

    // Values sampled in the most recent step
    int s_gv, s_go, s_br, s_ep, s_enc, s_err;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Reflected-Gray table built by mirroring: the upper half is the lower half
    // reversed with the new top bit set.
    task automatic build_gray_tab();
        gray_tab[0] = 0;
        gray_tab[1] = 1;
        for (int k = 1; k < 4; k++) begin
            for (int i = 0; i < (1 << k); i++) begin
                gray_tab[(1 << k) + i] = (1 << k) + gray_tab[(1 << k) - 1 - i];
            end
        end
    endtask

    task automatic model_clear();
        m_full = 0; m_gray = 0; m_errp = 0; m_enc = 0; m_err = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs to the model at the
    // negative edge, then advance the model across the rising edge.
    task automatic step(input int v, input int d, input int r, input int rs);
        int rdy, acc, fire;
        bcd_valid  = v[0];
        bcd_in     = 4'(d);
        gray_ready = r[0];
        rst        = rs[0];
        @(negedge clk);
        s_gv  = int'(gray_valid);
        s_go  = int'(gray_out);
        s_br  = int'(bcd_ready);
        s_ep  = int'(err_pulse);
        s_enc = int'(enc_cnt);
        s_err = int'(err_cnt);
        check("gray_valid", s_gv, m_full);
        check("gray_out", s_go, m_gray);
        check("bcd_ready", s_br, (m_full == 0 || r != 0) ? 1 : 0);
        check("err_pulse", s_ep, m_errp);
        check("enc_cnt", s_enc, m_enc);
        check("err_cnt", s_err, m_err);
        if (s_ep != 0) n_pulses++;
        if (s_gv != 0 && r != 0 && rs == 0)
            $display("xfer gray_out=%04b enc_cnt=%0d err_cnt=%0d t=%0t", 4'(s_go), s_enc, s_err, $time);
        @(posedge clk);
        if (rs != 0) begin
            model_clear();
        end else begin
            rdy  = (m_full == 0 || r != 0) ? 1 : 0;
            acc  = (v != 0 && rdy != 0) ? 1 : 0;
            fire = (m_full != 0 && r != 0) ? 1 : 0;
            m_errp = (acc != 0 && d > 9) ? 1 : 0;
            if (fire != 0) begin
                m_enc  = (m_enc + 1) % 256;
                m_full = 0;
            end
            if (acc != 0 && d > 9 && m_err < 255) m_err++;
            if (acc != 0 && d <= 9) begin
                m_full = 1;
                m_gray = gray_tab[d];
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
    endtask

    logic [3:0] exp_s2[10];

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_pulses = 0;
        build_gray_tab();
        exp_s2 = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                   4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};
        rst = 1'b1; bcd_valid = 1'b0; bcd_in = 4'd0; gray_ready = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        do_reset();

        // Reset state
        step(0, 0, 0, 0);
        check("rst_gray_valid", s_gv, 0);
        check("rst_gray_out", s_go, 0);
        check("rst_bcd_ready", s_br, 1);
        check("rst_enc_cnt", s_enc, 0);
        check("rst_err_cnt", s_err, 0);

        // Scenario 1: digit 5
        step(1, 5, 1, 0);
        step(0, 0, 1, 0);
        check("s1_gray_valid", s_gv, 1);
        check("s1_gray_out", s_go, 'b0111);
        step(0, 0, 1, 0);
        check("s1_enc_cnt", s_enc, 1);
        check("s1_empty", s_gv, 0);

        // Scenario 2: stream 0..9 back-to-back
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            step((i < 10) ? 1 : 0, i % 10, 1, 0);
            if (i >= 1) begin
                check("s2_gray_valid", s_gv, 1);
                check("s2_gray_out", s_go, int'(exp_s2[i - 1]));
            end
        end
        step(0, 0, 1, 0);
        check("s2_enc_cnt", s_enc, 10);

        // Scenario 3: invalid digit 12
        do_reset();
        step(1, 12, 1, 0);
        step(0, 0, 1, 0);
        check("s3_gray_valid", s_gv, 0);
        check("s3_err_pulse", s_ep, 1);
        step(0, 0, 1, 0);
        check("s3_err_pulse_off", s_ep, 0);
        check("s3_err_cnt", s_err, 1);

        // Scenario 4: backpressure after loading 9
        do_reset();
        step(1, 9, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 3, 0, 0);
            check("s4_hold_out", s_go, 'b1101);
            check("s4_hold_ready", s_br, 0);
        end
        step(1, 3, 1, 0);
        check("s4_release_out", s_go, 'b1101);
        step(0, 0, 1, 0);
        check("s4_next_valid", s_gv, 1);
        check("s4_next_out", s_go, 'b0010);
        step(0, 0, 1, 0);
        check("s4_enc_cnt", s_enc, 2);

        // Scenario 5: counter wrap and error saturation
        do_reset();
        for (int i = 0; i < 256; i++) step(1, int'($urandom_range(9, 0)), 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("s5_enc_wrap", s_enc, 0);
        n_pulses = 0;
        for (int i = 0; i < 300; i++) step(1, int'($urandom_range(15, 10)), 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("s5_err_sat", s_err, 255);
        check("s5_pulses", n_pulses, 300);

        // Scenario 6: reset while FULL and stalled
        do_reset();
        step(1, 7, 0, 0);
        step(0, 0, 0, 0);
        check("s6_full", s_gv, 1);
        step(1, 2, 0, 1);
        step(0, 0, 0, 0);
        check("s6_gray_valid", s_gv, 0);
        check("s6_enc_cnt", s_enc, 0);
        check("s6_err_cnt", s_err, 0);
        check("s6_bcd_ready", s_br, 1);
        step(0, 0, 1, 0);
        check("s6_no_ghost", s_gv, 0);
        check("s6_enc_after", s_enc, 0);

        // Randomized traffic, including occasional resets and invalid digits
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(3, 0) != 0) ? 1 : 0,
                 int'($urandom_range(15, 0)),
                 ($urandom_range(2, 0) != 0) ? 1 : 0,
                 ($urandom_range(127, 0) == 0) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
